// File: rtl/gen_bus_console_responder.sv
// Generic-bus responder owning the console character port and a status word.
// Optional CONSOLE_DROP_ON_FULL_EN: full-FIFO console writes are dropped (sets overflow) instead of stalling.
module gen_bus_console_responder #(
  parameter int          FIFO_DEPTH   = 8,
  parameter int          WAIT_STATES  = 1,
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000_0000,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_0004
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] addr,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, STALL, RESP} state_t;

  state_t          state, state_n;
  logic [3:0]      wcnt, wcnt_n;
  logic [31:0]     a_q;
  logic [7:0]      ch_q;
  logic            be3_q, clr_q, wr_q;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            full, pop, push, room_blk;
  logic            con_push, con_push_in, stall_need, stall_in;
  logic            ovf;
  logic [31:0]     rd_val;

  logic unused_bits;
  assign unused_bits = ^{wdata[23:1], byte_en[2:0]};

  assign full       = count == CW'(FIFO_DEPTH);
  assign char_valid = count != '0;
  assign char_data  = char_valid ? mem[head] : 8'h00;
  assign pop        = char_valid & char_ready;
  // A pop this cycle frees a slot before the pending push lands.
  assign room_blk   = full & ~pop;

  assign con_push    = wr_q & (a_q == CONSOLE_ADDR) & be3_q;
  assign con_push_in = wen & (addr == CONSOLE_ADDR) & byte_en[3];

`ifdef CONSOLE_DROP_ON_FULL_EN
  assign stall_need = 1'b0;
  assign stall_in   = 1'b0;
`else
  assign stall_need = con_push & room_blk;
  assign stall_in   = con_push_in & room_blk;
`endif

  assign push     = (state == RESP) & con_push & ~room_blk;
  assign overflow = ovf;

  always_comb begin
    rd_val = 32'hBAD0_BAD0;
    if (a_q == CONSOLE_ADDR)     rd_val = 32'h0;
    else if (a_q == STATUS_ADDR) rd_val = {8'h00, 8'(count), 15'h0, ovf};
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    busy    = 1'b1;
    rdata   = 32'h0;
    case (state)
      IDLE: if (ren | wen) begin
        wcnt_n = 4'd0;
        if (WAIT_STATES > 0) state_n = WAIT;
        else                 state_n = stall_in ? STALL : RESP;
      end
      WAIT: begin
        if (wcnt == 4'(WAIT_STATES - 1)) state_n = stall_need ? STALL : RESP;
        else                             wcnt_n  = wcnt + 4'd1;
      end
      STALL: if (!room_blk) state_n = RESP;
      RESP: begin
        busy    = 1'b0;
        state_n = IDLE;
        if (!wr_q) rdata = rd_val;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      wcnt  <= 4'd0;
      a_q   <= 32'h0;
      ch_q  <= 8'h0;
      be3_q <= 1'b0;
      clr_q <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (state == IDLE && (ren | wen)) begin
        a_q   <= addr;
        ch_q  <= wdata[31:24];
        be3_q <= byte_en[3];
        clr_q <= wdata[0];
        wr_q  <= wen;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= ch_q;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef CONSOLE_DROP_ON_FULL_EN
  always_ff @(posedge CLK) begin
    if (!nRST) ovf <= 1'b0;
    else if (state == RESP && con_push && room_blk) ovf <= 1'b1;
    else if (state == RESP && wr_q && a_q == STATUS_ADDR && clr_q) ovf <= 1'b0;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_gen_bus_console_responder.sv
// Directed bench for gen_bus_console_responder (FIFO_DEPTH=8, WAIT_STATES=1).
module tb_gen_bus_console_responder;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        ren = 1'b0, wen = 1'b0, char_ready = 1'b0;
  logic [3:0]  byte_en = '0;
  logic        busy, char_valid, overflow;
  logic [7:0]  char_data;

  int n_chk = 0, n_pass = 0;

  gen_bus_console_responder #(.FIFO_DEPTH(8), .WAIT_STATES(1)) dut (
    .CLK(CLK), .nRST(nRST), .addr(addr), .ren(ren), .wen(wen), .wdata(wdata),
    .byte_en(byte_en), .rdata(rdata), .busy(busy), .char_valid(char_valid),
    .char_data(char_data), .char_ready(char_ready), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Cycle 0 is the cycle the request is first presented in IDLE.
  task automatic xact(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd, output int lat);
    logic zero_ok;
    zero_ok = 1'b1;
    lat = -1;
    rd = 32'hxxxx_xxxx;
    @(posedge CLK); #1;
    ren = r; wen = w; addr = a; wdata = d; byte_en = be;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (!busy) begin lat = k; rd = rdata; break; end
      if (rdata !== 32'h0) zero_ok = 1'b0;
    end
    ren = 1'b0; wen = 1'b0;
    chk("rdata_zero_while_busy", {31'h0, zero_ok}, 32'h1);
  endtask

  task automatic pop_chk(input logic [7:0] exp);
    @(negedge CLK);
    chk("pop_valid", {31'h0, char_valid}, 32'h1);
    chk("pop_data", {24'h0, char_data}, {24'h0, exp});
    char_ready = 1'b1;
    @(posedge CLK); #1;
    char_ready = 1'b0;
  endtask

  vec_t        v[13];
  logic [31:0] rd;
  int          lat;
  logic        stuck;

  initial begin
    v[0]  = '{1'b0, 1'b1, 32'h0,  32'h4100_0000, 4'hf, 32'h0,         "wr_A"};
    v[1]  = '{1'b1, 1'b0, 32'h4,  32'h0,         4'hf, 32'h0001_0000, "st_1"};
    v[2]  = '{1'b0, 1'b1, 32'h0,  32'h4200_0000, 4'hf, 32'h0,         "wr_B"};
    v[3]  = '{1'b0, 1'b1, 32'h0,  32'h5A00_0000, 4'h7, 32'h0,         "wr_nobe3"};
    v[4]  = '{1'b0, 1'b1, 32'h0,  32'h4300_0000, 4'h8, 32'h0,         "wr_C"};
    v[5]  = '{1'b1, 1'b0, 32'h4,  32'h0,         4'hf, 32'h0003_0000, "st_3"};
    v[6]  = '{1'b1, 1'b0, 32'h0,  32'h0,         4'hf, 32'h0,         "rd_console"};
    v[7]  = '{1'b1, 1'b0, 32'h10, 32'h0,         4'hf, 32'hBAD0_BAD0, "rd_bad"};
    v[8]  = '{1'b1, 1'b1, 32'h10, 32'h4400_0000, 4'hf, 32'h0,         "rw_bad"};
    v[9]  = '{1'b0, 1'b1, 32'h10, 32'h4500_0000, 4'hf, 32'h0,         "wr_bad"};
    v[10] = '{1'b1, 1'b0, 32'h4,  32'h0,         4'hf, 32'h0003_0000, "st_3b"};
    v[11] = '{1'b0, 1'b1, 32'h4,  32'h1,         4'hf, 32'h0,         "wr_status"};
    v[12] = '{1'b1, 1'b0, 32'h8,  32'h0,         4'hf, 32'hBAD0_BAD0, "rd_bad8"};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", {31'h0, busy}, 32'h1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_valid", {31'h0, char_valid}, 32'h0);
    chk("rst_data", {24'h0, char_data}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    foreach (v[i]) begin
      xact(v[i].r, v[i].w, v[i].a, v[i].d, v[i].be, rd, lat);
      chk({v[i].nm, "_lat"}, lat, 2);
      chk({v[i].nm, "_rdata"}, rd, v[i].exp);
    end

    pop_chk(8'h41);
    pop_chk(8'h42);
    pop_chk(8'h43);
    @(negedge CLK);
    chk("drained_valid", {31'h0, char_valid}, 32'h0);
    chk("drained_data", {24'h0, char_data}, 32'h0);

    // Fill the FIFO, then a 9th console write
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'(8'h10 + i);
      xact(1'b0, 1'b1, 32'h0, {b, 24'h0}, 4'hf, rd, lat);
      chk("fill_lat", lat, 2);
    end
    xact(1'b1, 1'b0, 32'h4, 32'h0, 4'hf, rd, lat);
    chk("st_full", rd, 32'h0008_0000);

`ifdef CONSOLE_DROP_ON_FULL_EN
    xact(1'b0, 1'b1, 32'h0, 32'h9900_0000, 4'hf, rd, lat);
    chk("drop_lat", lat, 2);
    @(negedge CLK);
    chk("drop_ovf", {31'h0, overflow}, 32'h1);
    xact(1'b1, 1'b0, 32'h4, 32'h0, 4'hf, rd, lat);
    chk("st_ovf", rd, 32'h0008_0001);
    xact(1'b0, 1'b1, 32'h4, 32'h1, 4'hf, rd, lat);
    @(negedge CLK);
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 8; i++) pop_chk(8'(8'h10 + i));
`else
    stuck = 1'b1;
    @(posedge CLK); #1;
    wen = 1'b1; addr = 32'h0; wdata = 32'h9900_0000; byte_en = 4'hf;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (busy !== 1'b1 || rdata !== 32'h0) stuck = 1'b0;
    end
    chk("stall_busy", {31'h0, stuck}, 32'h1);
    @(posedge CLK); #1;
    char_ready = 1'b1;
    @(posedge CLK); #1;
    char_ready = 1'b0;
    @(negedge CLK);
    chk("stall_release", {31'h0, busy}, 32'h0);
    chk("stall_rdata", rdata, 32'h0);
    wen = 1'b0;
    @(negedge CLK);
    chk("stall_ovf", {31'h0, overflow}, 32'h0);
    xact(1'b1, 1'b0, 32'h4, 32'h0, 4'hf, rd, lat);
    chk("st_after_stall", rd, 32'h0008_0000);
    for (int i = 1; i < 8; i++) pop_chk(8'(8'h10 + i));
    pop_chk(8'h99);
`endif
    @(negedge CLK);
    chk("empty_after_full", {31'h0, char_valid}, 32'h0);

    // Reset in the middle of a transaction with two entries queued
    xact(1'b0, 1'b1, 32'h0, 32'h6100_0000, 4'hf, rd, lat);
    xact(1'b0, 1'b1, 32'h0, 32'h6200_0000, 4'hf, rd, lat);
    @(posedge CLK); #1;
    wen = 1'b1; addr = 32'h0; wdata = 32'h5500_0000; byte_en = 4'hf;
    @(posedge CLK); #1;
    nRST = 1'b0; wen = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_busy", {31'h0, busy}, 32'h1);
    chk("mid_rst_valid", {31'h0, char_valid}, 32'h0);
    xact(1'b1, 1'b0, 32'h4, 32'h0, 4'hf, rd, lat);
    chk("mid_rst_status", rd, 32'h0);
    xact(1'b0, 1'b1, 32'h0, 32'h6600_0000, 4'hf, rd, lat);
    chk("post_rst_lat", lat, 2);
    pop_chk(8'h66);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
